// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_add_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple-carry adder; overflow is the nibble carry-out.
module adder_4bit
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                overflow
);
    logic [NIBBLE_W:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carry_in};
    assign sum      = total[NIBBLE_W-1:0];
    assign overflow = total[NIBBLE_W];
endmodule

// File: rtl/nibble_add_sequencer.sv
// Adds two NUM_NIBBLES*4-bit operands one nibble per cycle through a single
// 4-bit adder, LSB nibble first, and publishes the sum with a done pulse.
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter  int NUM_NIBBLES = 4,
    localparam int W           = NIBBLE_W * NUM_NIBBLES
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow
);
    localparam int CNT_W = $clog2(NUM_NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NIBBLES - 1);

    state_t                 state;
    logic [W-1:0]           op_a;
    logic [W-1:0]           op_b;
    // Holds the completed lower nibbles; the top nibble comes straight from the adder.
    logic [W-NIBBLE_W-1:0]  work;
    logic                   carry_q;
    logic [CNT_W-1:0]       nib_cnt;
    logic [NIBBLE_W-1:0]    nib_sum;
    logic                   nib_cout;

    adder_4bit u_adder (
        .a        (op_a[NIBBLE_W-1:0]),
        .b        (op_b[NIBBLE_W-1:0]),
        .carry_in (carry_q),
        .sum      (nib_sum),
        .overflow (nib_cout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            work     <= '0;
            carry_q  <= 1'b0;
            nib_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a    <= a_in;
                        op_b    <= b_in;
                        carry_q <= carry_in;
                        nib_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    work    <= (W-NIBBLE_W)'({nib_sum, work} >> NIBBLE_W);
                    carry_q <= nib_cout;
                    op_a    <= op_a >> NIBBLE_W;
                    op_b    <= op_b >> NIBBLE_W;
                    if (nib_cnt == LAST) begin
                        result   <= {nib_sum, work};
                        overflow <= nib_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        nib_cnt <= nib_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
